// File: rtl/spell_mem_pkg.sv
// spell_mem_pkg
//   Shared types and constants for the SPELL memory arbiter slice.
//   - state_t        : access sequencer states (IDLE, ISSUE, WAIT, DONE)
//   - GRANT_CPU/HOST : encoding of the grant_host flag and last-grant register
//   - *_DEFAULT      : default timeout length and counter width
//   - rr_pick_host   : two-way round-robin choice used by the arbiter
package spell_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic GRANT_CPU  = 1'b0;
    localparam logic GRANT_HOST = 1'b1;

    // Has to outlast the memory's 512-cycle init sweep.
    localparam int TIMEOUT_CYCLES_DEFAULT = 1024;
    localparam int CNT_W_DEFAULT          = 11;

    // Returns 1 when the host should be granted. A lone requester always
    // wins; on a tie the side that was not granted last goes first.
    function automatic logic rr_pick_host(input logic cpu_req,
                                          input logic host_req,
                                          input logic last_host);
        logic pick;
        if (cpu_req && host_req) begin
            pick = ~last_host;
        end else begin
            pick = host_req;
        end
        return pick;
    endfunction

endpackage

// File: rtl/spell_mem_rr_arbiter.sv
// spell_mem_rr_arbiter
//   Two-way round-robin pick between the CPU and the host port.
//   The grant is combinational; the last-grant register only moves when the
//   sequencer actually accepts the pick (commit strobe).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   cpu_req      : CPU request
//   host_req     : host request
//   commit       : sequencer is in IDLE and will take the current pick
//   grant_valid  : at least one request is pending
//   grant_host   : chosen requester (GRANT_HOST / GRANT_CPU)
module spell_mem_rr_arbiter
    import spell_mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic host_req,
    input  logic commit,
    output logic grant_valid,
    output logic grant_host
);

    logic last_host;

    // Last-grant memory. Resetting to HOST makes the CPU win the first tie
    // after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_host <= GRANT_HOST;
        end else if (commit && grant_valid) begin
            last_host <= grant_host;
        end
    end

    // Combinational pick from the current requests and the last winner.
    always_comb begin
        grant_valid = cpu_req | host_req;
        grant_host  = rr_pick_host(cpu_req, host_req, last_host);
    end

endmodule

// File: rtl/spell_mem_arbiter.sv
// spell_mem_arbiter
//   Sole driver of the SPELL memory wrapper's request inputs. Arbitrates
//   between the CPU and the host port, runs the select/data_ready handshake,
//   returns read data with a one-cycle ack, and aborts any access that waits
//   TIMEOUT_CYCLES without data_ready (ack with err = 1, rdata = 0).
//   All outputs are registered.
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   cpu_req/write/data_type/addr/wdata   : CPU request (held until cpu_ack)
//   cpu_ack                         : one-cycle completion pulse to the CPU
//   host_req/write/data_type/addr/wdata  : host request (held until host_ack)
//   host_ack                        : one-cycle completion pulse to the host
//   rdata, err                      : read data / timeout flag, valid with an ack
//   mem_select/write/type_data/addr/data_in : to the memory wrapper
//   mem_data_out, mem_data_ready    : from the memory wrapper
//   busy                            : sequencer is not IDLE
//   grant_host                      : owner of the current or last access
module spell_mem_arbiter
    import spell_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int CNT_W          = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       cpu_write,
    input  logic       cpu_data_type,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    input  logic       host_req,
    input  logic       host_write,
    input  logic       host_data_type,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic [7:0] rdata,
    output logic       err,
    output logic       mem_select,
    output logic       mem_write,
    output logic       mem_type_data,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data_in,
    input  logic [7:0] mem_data_out,
    input  logic       mem_data_ready,
    output logic       busy,
    output logic       grant_host
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;

    logic              pick_valid;
    logic              pick_host;
    logic              in_idle;

    logic              cpu_ack_next;
    logic              host_ack_next;
    logic [7:0]        rdata_next;
    logic              err_next;
    logic              select_next;
    logic              write_next;
    logic              type_next;
    logic [7:0]        addr_next;
    logic [7:0]        wdata_next;
    logic              busy_next;
    logic              grant_host_next;

    assign in_idle = (state == IDLE);

    spell_mem_rr_arbiter u_rr (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .host_req    (host_req),
        .commit      (in_idle),
        .grant_valid (pick_valid),
        .grant_host  (pick_host)
    );

    // State, timeout counter and every output register. Reset drops
    // mem_select and any pending ack immediately, so an aborted access is
    // never acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            cpu_ack       <= 1'b0;
            host_ack      <= 1'b0;
            rdata         <= 8'h00;
            err           <= 1'b0;
            mem_select    <= 1'b0;
            mem_write     <= 1'b0;
            mem_type_data <= 1'b0;
            mem_addr      <= 8'h00;
            mem_data_in   <= 8'h00;
            busy          <= 1'b0;
            grant_host    <= GRANT_CPU;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            cpu_ack       <= cpu_ack_next;
            host_ack      <= host_ack_next;
            rdata         <= rdata_next;
            err           <= err_next;
            mem_select    <= select_next;
            mem_write     <= write_next;
            mem_type_data <= type_next;
            mem_addr      <= addr_next;
            mem_data_in   <= wdata_next;
            busy          <= busy_next;
            grant_host    <= grant_host_next;
        end
    end

    // Next-state and next-output logic. The memory request fields hold their
    // latched values between accesses; ack/rdata/err default to 0 so they
    // only live for the single DONE cycle.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        cpu_ack_next    = 1'b0;
        host_ack_next   = 1'b0;
        rdata_next      = 8'h00;
        err_next        = 1'b0;
        select_next     = mem_select;
        write_next      = mem_write;
        type_next       = mem_type_data;
        addr_next       = mem_addr;
        wdata_next      = mem_data_in;
        grant_host_next = grant_host;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next      = ISSUE;
                    select_next     = 1'b1;
                    grant_host_next = pick_host;
                    if (pick_host == GRANT_HOST) begin
                        write_next = host_write;
                        type_next  = host_data_type;
                        addr_next  = host_addr;
                        wdata_next = host_wdata;
                    end else begin
                        write_next = cpu_write;
                        type_next  = cpu_data_type;
                        addr_next  = cpu_addr;
                        wdata_next = cpu_wdata;
                    end
                end
            end

            // data_ready here still mirrors the select of the previous
            // cycle, so it is not looked at.
            ISSUE: begin
                state_next = WAIT;
                cnt_next   = '0;
            end

            WAIT: begin
                cnt_next = cnt + CNT_W'(1);
                if (mem_data_ready) begin
                    state_next  = DONE;
                    select_next = 1'b0;
                    rdata_next  = mem_write ? 8'h00 : mem_data_out;
                end else if (cnt == CNT_LAST) begin
                    state_next  = DONE;
                    select_next = 1'b0;
                    err_next    = 1'b1;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next  = IDLE;
                select_next = 1'b0;
            end
        endcase

        // The ack goes to whoever owns the access, on entry to DONE.
        if (state == WAIT && state_next == DONE) begin
            cpu_ack_next  = (grant_host == GRANT_CPU);
            host_ack_next = (grant_host == GRANT_HOST);
        end

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// tb_spell_mem_arbiter
//   Self-checking bench for spell_mem_arbiter. Contains a behavioural model
//   of the memory wrapper (init sweep, data_ready = registered select) and a
//   transaction-level model that predicts, at each grant, the ack cycle,
//   owner, rdata and err from closed-form timing; every cycle the DUT
//   outputs are compared against that prediction.
module tb_spell_mem_arbiter;

    localparam int T     = 16;
    localparam int CW    = 5;
    localparam int SWEEP = 10;
    localparam int NEVER = 1 << 30;
    localparam int MAXW  = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_req = 1'b0, cpu_write = 1'b0, cpu_data_type = 1'b0;
    logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00;
    logic       host_req = 1'b0, host_write = 1'b0, host_data_type = 1'b0;
    logic [7:0] host_addr = 8'h00, host_wdata = 8'h00;
    logic       cpu_ack, host_ack, err, busy, grant_host;
    logic [7:0] rdata;
    logic       mem_select, mem_write, mem_type_data;
    logic [7:0] mem_addr, mem_data_in;
    logic [7:0] mem_data_out = 8'h00;
    logic       mem_data_ready = 1'b0;

    logic       mem_rst_n = 1'b0;
    bit         stuck = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spell_mem_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req        (cpu_req),
        .cpu_write      (cpu_write),
        .cpu_data_type  (cpu_data_type),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_ack        (cpu_ack),
        .host_req       (host_req),
        .host_write     (host_write),
        .host_data_type (host_data_type),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_ack       (host_ack),
        .rdata          (rdata),
        .err            (err),
        .mem_select     (mem_select),
        .mem_write      (mem_write),
        .mem_type_data  (mem_type_data),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .mem_data_ready (mem_data_ready),
        .busy           (busy),
        .grant_host     (grant_host)
    );

    // Memory wrapper model: SWEEP cycles of init after mem_rst_n releases,
    // then data_ready follows select by one cycle. 'stuck' freezes it.
    bit [7:0] mem_code [256];
    bit [7:0] mem_data [256];
    int       icnt = 0;

    always @(posedge clk) begin
        if (!mem_rst_n) begin
            icnt           <= 0;
            mem_data_ready <= 1'b0;
        end else if (icnt < SWEEP) begin
            icnt           <= icnt + 1;
            mem_data_ready <= 1'b0;
        end else begin
            mem_data_ready <= mem_select && !stuck;
            if (mem_select && !stuck) begin
                if (mem_type_data) begin
                    if (mem_write) mem_data[mem_addr] <= mem_data_in;
                    mem_data_out <= mem_data[mem_addr];
                end else begin
                    if (mem_write) mem_code[mem_addr] <= mem_data_in;
                    mem_data_out <= mem_code[mem_addr];
                end
            end
        end
    end

    // Transaction model state
    int       edge_n = 0;
    int       init_edge = NEVER;
    bit       mem_was_low = 1'b1;
    bit       last_host = 1'b1;
    int       free_edge = 0;
    bit       a_valid = 1'b0;
    bit       a_host = 1'b0, a_write = 1'b0, a_type = 1'b0, a_err = 1'b0;
    bit [7:0] a_addr = 8'h00, a_wdata = 8'h00, a_rdata = 8'h00;
    int       a_g = 0, a_ack = 0;
    bit [7:0] sh_code [256];
    bit [7:0] sh_data [256];

    // Advance the model by the posedge that just happened. Inputs are only
    // changed right after a negedge, so current values equal those the DUT saw.
    task modelStep();
        int er;
        if (!mem_rst_n) begin
            mem_was_low = 1'b1;
            init_edge   = NEVER;
        end else if (mem_was_low) begin
            mem_was_low = 1'b0;
            init_edge   = edge_n + SWEEP;
        end
        if (rst) begin
            a_valid   = 1'b0;
            last_host = 1'b1;
            free_edge = 0;
        end else if (edge_n >= free_edge && (cpu_req || host_req)) begin
            a_host    = (cpu_req && host_req) ? !last_host : host_req;
            last_host = a_host;
            a_write   = a_host ? host_write     : cpu_write;
            a_type    = a_host ? host_data_type : cpu_data_type;
            a_addr    = a_host ? host_addr      : cpu_addr;
            a_wdata   = a_host ? host_wdata     : cpu_wdata;
            a_g       = edge_n;
            er        = (a_g + 1 > init_edge) ? a_g + 1 : init_edge;
            if (stuck || er > a_g + T) begin
                a_ack   = a_g + T + 1;
                a_err   = 1'b1;
                a_rdata = 8'h00;
            end else begin
                a_ack   = er + 1;
                a_err   = 1'b0;
                a_rdata = a_write ? 8'h00 : (a_type ? sh_data[a_addr] : sh_code[a_addr]);
                if (a_write) begin
                    if (a_type) sh_data[a_addr] = a_wdata;
                    else        sh_code[a_addr] = a_wdata;
                end
            end
            a_valid   = 1'b1;
            free_edge = a_ack + 2;
        end
    endtask

    task compareOutputs();
        logic [31:0] act, exp;
        bit s, b, d;
        exp = 32'h0;
        if (!rst && a_valid) begin
            s   = (edge_n >= a_g) && (edge_n < a_ack);
            b   = (edge_n >= a_g) && (edge_n <= a_ack);
            d   = (edge_n == a_ack);
            exp = {d && !a_host, d && a_host, b, a_host, s, a_write, a_type,
                   d && a_err, d ? a_rdata : 8'h00, a_addr, a_wdata};
        end
        act = {cpu_ack, host_ack, busy, grant_host, mem_select, mem_write,
               mem_type_data, err, rdata, mem_addr, mem_data_in};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL outputs at edge %0d: got %h, want %h", edge_n, act, exp);
        end
    endtask

    task tick();
        @(negedge clk);
        edge_n++;
        modelStep();
        compareOutputs();
    endtask

    task checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task applyStimulus(input bit who, input bit wr, input bit ty,
                       input logic [7:0] ad, input logic [7:0] wd);
        if (who) begin
            host_write = wr; host_data_type = ty; host_addr = ad; host_wdata = wd;
            host_req = 1'b1;
        end else begin
            cpu_write = wr; cpu_data_type = ty; cpu_addr = ad; cpu_wdata = wd;
            cpu_req = 1'b1;
        end
    endtask

    // One access from an idle DUT; returns ack data, latency and the number
    // of cycles mem_select was seen high. Leaves the DUT back in IDLE.
    task access(input bit who, input bit wr, input bit ty,
                input logic [7:0] ad, input logic [7:0] wd,
                output logic [7:0] rd, output bit er, output int lat, output int sel);
        bit got;
        applyStimulus(who, wr, ty, ad, wd);
        got = 1'b0; lat = 0; sel = 0; rd = 8'h00; er = 1'b0;
        for (int i = 1; i <= MAXW && !got; i++) begin
            tick();
            if (mem_select) sel++;
            if (who ? host_ack : cpu_ack) begin
                got = 1'b1; lat = i; rd = rdata; er = err;
            end
        end
        cpu_req = 1'b0;
        host_req = 1'b0;
        checkOutput("ack_seen", got, 1);
        tick();
    endtask

    // Both requesters held: CPU reads code 0x10, host reads data 0x20.
    task runBoth(input int n_acks);
        int got, t_prev;
        bit want_host;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h20, 8'h00);
        got = 0; t_prev = 0; want_host = 1'b0;
        for (int i = 1; i <= 60 && got < n_acks; i++) begin
            tick();
            if (cpu_ack || host_ack) begin
                checkOutput("rr_owner", host_ack, want_host);
                checkOutput("rr_rdata", rdata, host_ack ? 8'h3C : 8'hA5);
                checkOutput("rr_spacing", i - t_prev, (got == 0) ? 3 : 4);
                t_prev = i; got++; want_host = !want_host;
            end
        end
        cpu_req = 1'b0;
        host_req = 1'b0;
        checkOutput("rr_ack_count", got, n_acks);
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] rd;
        bit er;
        int lat, sel;

        // Reset with memory coming out of its sweep underneath
        repeat (2) tick();
        mem_rst_n = 1'b1;
        repeat (SWEEP + 2) tick();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_select", mem_select, 0);
        checkOutput("reset_grant", grant_host, 0);
        rst = 1'b0;

        // Host preloads code 0x10, then the CPU reads it back
        access(1'b1, 1'b1, 1'b0, 8'h10, 8'hA5, rd, er, lat, sel);
        checkOutput("host_wr_latency", lat, 3);
        access(1'b0, 1'b0, 1'b0, 8'h10, 8'h00, rd, er, lat, sel);
        checkOutput("cpu_rd_data", rd, 8'hA5);
        checkOutput("cpu_rd_err", er, 0);
        checkOutput("cpu_rd_latency", lat, 3);
        checkOutput("cpu_rd_select_cycles", sel, 2);

        // Host write to data memory, CPU and host read it
        access(1'b1, 1'b1, 1'b1, 8'h20, 8'h3C, rd, er, lat, sel);
        checkOutput("host_wr_type", mem_type_data, 1);
        access(1'b0, 1'b0, 1'b1, 8'h20, 8'h00, rd, er, lat, sel);
        checkOutput("cpu_rd_3c", rd, 8'h3C);
        checkOutput("cpu_rd_type", mem_type_data, 1);
        access(1'b1, 1'b0, 1'b1, 8'h20, 8'h00, rd, er, lat, sel);
        checkOutput("host_rd_3c", rd, 8'h3C);

        // Continuous contention: CPU, HOST, CPU, HOST
        runBoth(4);

        // Access issued 5 cycles into a fresh init sweep
        mem_rst_n = 1'b0;
        repeat (2) tick();
        mem_rst_n = 1'b1;
        repeat (5) tick();
        access(1'b1, 1'b1, 1'b1, 8'h30, 8'h77, rd, er, lat, sel);
        checkOutput("sweep_err", er, 0);
        checkOutput("sweep_latency", lat, 7);
        access(1'b0, 1'b0, 1'b1, 8'h30, 8'h00, rd, er, lat, sel);
        checkOutput("sweep_readback", rd, 8'h77);
        checkOutput("post_sweep_latency", lat, 3);

        // Memory never answers
        stuck = 1'b1;
        access(1'b0, 1'b0, 1'b0, 8'h10, 8'h00, rd, er, lat, sel);
        checkOutput("timeout_latency", lat, T + 2);
        checkOutput("timeout_err", er, 1);
        checkOutput("timeout_rdata", rd, 0);
        stuck = 1'b0;

        // Reset in the middle of WAIT
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
        tick();
        tick();
        checkOutput("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async_select", mem_select, 0);
        checkOutput("rst_async_busy", busy, 0);
        checkOutput("rst_async_ack", cpu_ack, 0);
        cpu_req = 1'b0;
        tick();
        rst = 1'b0;
        runBoth(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
